// File: rtl/fp_clip_pkg.sv
// Shared types and constants for the floating-point hard clipper and its
// comparator sequencing.
package fp_clip_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HI_REQ,
        HI_WAIT,
        LO_REQ,
        LO_WAIT,
        OUT
    } clip_state_t;

    localparam int CMP_AEB_BIT = 0;
    localparam int CMP_AGB_BIT = 1;
    localparam int CMP_ALB_BIT = 2;
    localparam int FP_SIGN_BIT = 31;

    // Sign flip only; valid for any IEEE-754 single, including zeros and NaN.
    function automatic logic [31:0] fp_negate(input logic [31:0] value);
        return {~value[FP_SIGN_BIT], value[FP_SIGN_BIT-1:0]};
    endfunction

endpackage

// File: rtl/fp_cmp_watchdog.sv
// Cycle watchdog for multi-cycle arithmetic handshakes: counts while 'run'
// is high and flags 'expired' once CMP_TIMEOUT cycles have elapsed.
module fp_cmp_watchdog #(
    parameter int CMP_TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(CMP_TIMEOUT + 1);

    logic [CW-1:0] count;

    // Holds at the limit so 'expired' stays asserted until the next clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == CW'(CMP_TIMEOUT));

endmodule

// File: rtl/fp_hard_clipper.sv
// Hard clipper for float audio samples: sequences two compares against
// +/-threshold on a shared comparator. Optional stats via FP_CLIP_STATS_EN.
module fp_hard_clipper
    import fp_clip_pkg::*;
#(
    parameter int CMP_TIMEOUT = 15
`ifdef FP_CLIP_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_sample,
    input  logic [31:0] threshold,
    output logic        cmp_en,
    output logic [31:0] cmp_dataa,
    output logic [31:0] cmp_datab,
    input  logic [31:0] cmp_result,
    input  logic        cmp_done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sample,
    output logic        clip_flag,
    output logic        timeout_err
`ifdef FP_CLIP_STATS_EN
    ,
    input  logic             stat_clear,
    output logic [CNT_W-1:0] clip_count
`endif
);

    clip_state_t state;
    logic [31:0] sample_q;
    logic [31:0] thr_q;
    logic        wd_clear;
    logic        wd_run;
    logic        wd_expired;
    logic        clip_xfer;
    logic        unused_cmp_bits;

    // Equality and the upper result bits carry no decision here.
    assign unused_cmp_bits = ^{cmp_result[31:CMP_ALB_BIT+1], cmp_result[CMP_AEB_BIT]};

    assign wd_clear = (state == HI_REQ) || (state == LO_REQ);
    assign wd_run   = (state == HI_WAIT) || (state == LO_WAIT);

    fp_cmp_watchdog #(
        .CMP_TIMEOUT(CMP_TIMEOUT)
    ) u_watchdog (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (wd_clear),
        .run    (wd_run),
        .expired(wd_expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            sample_q    <= '0;
            thr_q       <= '0;
            in_ready    <= 1'b1;
            cmp_en      <= 1'b0;
            cmp_dataa   <= '0;
            cmp_datab   <= '0;
            out_valid   <= 1'b0;
            out_sample  <= '0;
            clip_flag   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sample_q  <= in_sample;
                        thr_q     <= threshold;
                        cmp_dataa <= in_sample;
                        cmp_datab <= threshold;
                        cmp_en    <= 1'b1;
                        in_ready  <= 1'b0;
                        state     <= HI_REQ;
                    end
                end
                HI_REQ: begin
                    cmp_en <= 1'b0;
                    state  <= HI_WAIT;
                end
                // A done in the expiry cycle still counts as a valid answer.
                HI_WAIT: begin
                    if (cmp_done) begin
                        if (cmp_result[CMP_AGB_BIT]) begin
                            out_sample  <= thr_q;
                            clip_flag   <= 1'b1;
                            timeout_err <= 1'b0;
                            out_valid   <= 1'b1;
                            state       <= OUT;
                        end else begin
                            cmp_datab <= fp_negate(thr_q);
                            cmp_en    <= 1'b1;
                            state     <= LO_REQ;
                        end
                    end else if (wd_expired) begin
                        out_sample  <= sample_q;
                        clip_flag   <= 1'b0;
                        timeout_err <= 1'b1;
                        out_valid   <= 1'b1;
                        state       <= OUT;
                    end
                end
                LO_REQ: begin
                    cmp_en <= 1'b0;
                    state  <= LO_WAIT;
                end
                LO_WAIT: begin
                    if (cmp_done) begin
                        if (cmp_result[CMP_ALB_BIT]) begin
                            out_sample <= fp_negate(thr_q);
                            clip_flag  <= 1'b1;
                        end else begin
                            out_sample <= sample_q;
                            clip_flag  <= 1'b0;
                        end
                        timeout_err <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= OUT;
                    end else if (wd_expired) begin
                        out_sample  <= sample_q;
                        clip_flag   <= 1'b0;
                        timeout_err <= 1'b1;
                        out_valid   <= 1'b1;
                        state       <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    cmp_en    <= 1'b0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign clip_xfer = out_valid && out_ready && clip_flag;

`ifdef FP_CLIP_STATS_EN
    // Saturating clip counter; a clear beats a same-cycle increment.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clip_count <= '0;
        end else if (stat_clear) begin
            clip_count <= '0;
        end else if (clip_xfer && (clip_count != {CNT_W{1'b1}})) begin
            clip_count <= clip_count + 1'b1;
        end
    end
`else
    logic unused_clip_xfer;
    assign unused_clip_xfer = clip_xfer;
`endif

endmodule

// File: tb/tb_fp_hard_clipper.sv
// Scoreboard bench for fp_hard_clipper with a behavioural comparator model
// whose results and latency are set per directed vector.
module tb_fp_hard_clipper;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_sample;
    logic [31:0] threshold;
    logic        cmp_en;
    logic [31:0] cmp_dataa;
    logic [31:0] cmp_datab;
    logic [31:0] cmp_result;
    logic        cmp_done;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sample;
    logic        clip_flag;
    logic        timeout_err;
`ifdef FP_CLIP_STATS_EN
    logic        stat_clear;
    logic [15:0] clip_count;
`endif

    always #5 clock = ~clock;

    fp_hard_clipper #(
        .CMP_TIMEOUT(15)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sample  (in_sample),
        .threshold  (threshold),
        .cmp_en     (cmp_en),
        .cmp_dataa  (cmp_dataa),
        .cmp_datab  (cmp_datab),
        .cmp_result (cmp_result),
        .cmp_done   (cmp_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample),
        .clip_flag  (clip_flag),
        .timeout_err(timeout_err)
`ifdef FP_CLIP_STATS_EN
        ,
        .stat_clear (stat_clear),
        .clip_count (clip_count)
`endif
    );

    typedef struct {
        logic [31:0] sample;
        logic        clip;
        logic        tmo;
        int          pulses;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pulses   = 0;

    // Comparator model configuration, set by the stimulus before each accept.
    logic [31:0] m_sample, m_thr, m_hi_res, m_lo_res, m_pend;
    bit          m_silent;
    int          m_delay;
    int          m_idx;
    int          m_cnt = 0;
    int          stray_req = 0;
    int          stray_ack = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Comparator: answers each cmp_en after m_delay negedges unless silent.
    initial begin
        cmp_done   = 1'b0;
        cmp_result = '0;
        forever begin
            @(negedge clock);
            cmp_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    cmp_done   = 1'b1;
                    cmp_result = m_pend;
                end
            end
            if (stray_req != stray_ack) begin
                cmp_done   = 1'b1;
                cmp_result = 32'h2;
                stray_ack++;
            end
            if (cmp_en && reset_n) begin
                checkOutput("cmp_dataa", cmp_dataa, m_sample);
                checkOutput("cmp_datab", cmp_datab,
                            (m_idx == 0) ? m_thr : {~m_thr[31], m_thr[30:0]});
                m_pend = (m_idx == 0) ? m_hi_res : m_lo_res;
                m_idx++;
                if (!m_silent) m_cnt = m_delay;
            end
        end
    end

    // Monitor: counts request pulses and scores every output transfer.
    always @(negedge clock) begin
        if (!reset_n) begin
            pulses = 0;
        end else begin
            if (cmp_en) pulses++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_output: got 0x%08h, expected none", out_sample);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("out_sample", out_sample, e.sample);
                    checkOutput("clip_flag", 32'(clip_flag), 32'(e.clip));
                    checkOutput("timeout_err", 32'(timeout_err), 32'(e.tmo));
                    checkOutput("cmp_pulses", 32'(pulses), 32'(e.pulses));
                end
                pulses = 0;
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] s, input logic [31:0] thr,
                                 input logic [31:0] hi, input logic [31:0] lo,
                                 input bit silent, input int delay,
                                 input logic [31:0] eo, input bit ec, input bit et,
                                 input int ep);
        exp_t e;
        int g = 0;
        @(negedge clock);
        while (!in_ready && g < 200) begin
            @(negedge clock);
            g++;
        end
        checkOutput("accept_ready", 32'(in_ready), 32'd1);
        m_sample = s;
        m_thr    = thr;
        m_hi_res = hi;
        m_lo_res = lo;
        m_silent = silent;
        m_delay  = delay;
        m_idx    = 0;
        e.sample = eo;
        e.clip   = ec;
        e.tmo    = et;
        e.pulses = ep;
        exp_q.push_back(e);
        in_sample = s;
        threshold = thr;
        in_valid  = 1'b1;
        @(negedge clock);
        in_valid  = 1'b0;
    endtask

    task automatic waitIdle();
        int g = 0;
        while ((exp_q.size() != 0 || !in_ready) && g < 300) begin
            @(negedge clock);
            g++;
        end
        checkOutput("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (20) @(negedge clock);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        checkOutput({tag, "_cmp_en"}, 32'(cmp_en), 32'd0);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_out_sample"}, out_sample, 32'd0);
        checkOutput({tag, "_clip_flag"}, 32'(clip_flag), 32'd0);
        checkOutput({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        checkOutput({tag, "_cmp_dataa"}, cmp_dataa, 32'd0);
        checkOutput({tag, "_cmp_datab"}, cmp_datab, 32'd0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] aborted");
    end

    initial begin
        int g;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_sample = '0;
        threshold = '0;
        out_ready = 1'b1;
        m_sample = '0; m_thr = '0; m_hi_res = '0; m_lo_res = '0; m_pend = '0;
        m_silent = 1'b0; m_delay = 4; m_idx = 0;
`ifdef FP_CLIP_STATS_EN
        stat_clear = 1'b0;
`endif
        repeat (3) @(negedge clock);
        checkReset("rst");
        reset_n = 1'b1;
        @(negedge clock);
        checkReset("post_rst");

        // Positive clip, negative clip, pass-through, equal, NaN.
        applyStimulus(32'h3F400000, 32'h3F000000, 32'h2, 32'h2, 0, 4, 32'h3F000000, 1, 0, 1);
        waitIdle();
        applyStimulus(32'hBF400000, 32'h3F000000, 32'h4, 32'h4, 0, 4, 32'hBF000000, 1, 0, 2);
        waitIdle();
        applyStimulus(32'h3E800000, 32'h3F000000, 32'h4, 32'h2, 0, 4, 32'h3E800000, 0, 0, 2);
        waitIdle();
        applyStimulus(32'h3F000000, 32'h3F000000, 32'h1, 32'h2, 0, 4, 32'h3F000000, 0, 0, 2);
        waitIdle();
        applyStimulus(32'h7FC00000, 32'h3F000000, 32'h0, 32'h0, 0, 4, 32'h7FC00000, 0, 0, 2);
        waitIdle();
        // Zero threshold: negative bound is -0.
        applyStimulus(32'h3F800000, 32'h00000000, 32'h2, 32'h2, 0, 4, 32'h00000000, 1, 0, 1);
        waitIdle();
        applyStimulus(32'hBF800000, 32'h00000000, 32'h4, 32'h4, 0, 4, 32'h80000000, 1, 0, 2);
        waitIdle();

        // Silent comparator, then a stray done while idle.
        applyStimulus(32'h3F400000, 32'h3F000000, 32'h2, 32'h2, 1, 4, 32'h3F400000, 0, 1, 1);
        waitIdle();
        stray_req++;
        repeat (4) begin
            @(negedge clock);
            checkOutput("stray_out_valid", 32'(out_valid), 32'd0);
            checkOutput("stray_in_ready", 32'(in_ready), 32'd1);
        end

        // Done coinciding with expiry wins; one cycle later it is too late.
        applyStimulus(32'h3F400000, 32'h3F000000, 32'h2, 32'h2, 0, 16, 32'h3F000000, 1, 0, 1);
        waitIdle();
        applyStimulus(32'h3F400000, 32'h3F000000, 32'h2, 32'h2, 0, 17, 32'h3F400000, 0, 1, 1);
        waitIdle();

        // Backpressure: output must hold while out_ready is low.
        out_ready = 1'b0;
        applyStimulus(32'h3F400000, 32'h3F000000, 32'h2, 32'h2, 0, 4, 32'h3F000000, 1, 0, 1);
        g = 0;
        while (!out_valid && g < 100) begin
            @(negedge clock);
            g++;
        end
        repeat (5) begin
            checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_out_sample", out_sample, 32'h3F000000);
            checkOutput("stall_clip_flag", 32'(clip_flag), 32'd1);
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
            @(negedge clock);
        end
        out_ready = 1'b1;
        waitIdle();
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);

        // Reset while the second compare is outstanding.
        applyStimulus(32'h3E800000, 32'h3F000000, 32'h4, 32'h2, 0, 4, 32'h3E800000, 0, 0, 2);
        g = 0;
        while (pulses < 2 && g < 100) begin
            @(negedge clock);
            g++;
        end
        checkOutput("lo_req_seen", 32'(pulses), 32'd2);
        @(negedge clock);
        reset_n = 1'b0;
        exp_q.delete();
        #2;
        checkReset("mid_rst");
        @(negedge clock);
        reset_n = 1'b1;
        waitIdle();
        checkReset("after_mid_rst");

`ifdef FP_CLIP_STATS_EN
        stat_clear = 1'b1;
        @(negedge clock);
        stat_clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h3F400000, 32'h3F000000, 32'h2, 32'h2, 0, 4, 32'h3F000000, 1, 0, 1);
            waitIdle();
        end
        applyStimulus(32'h3E800000, 32'h3F000000, 32'h4, 32'h2, 0, 4, 32'h3E800000, 0, 0, 2);
        waitIdle();
        checkOutput("clip_count", 32'(clip_count), 32'd3);
        stat_clear = 1'b1;
        @(negedge clock);
        stat_clear = 1'b0;
        @(negedge clock);
        checkOutput("clip_count_cleared", 32'(clip_count), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
